// File: rtl/down_timer.sv
// Loadable down-counter with pause, stop, restart and optional periodic auto-reload.
// Latency: Q shows the load value one edge after start; the terminal count lands N edges later.
// Backpressure: none; start/stop are sampled every edge and pause simply holds the count.
module down_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             auto_reload,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] Q,
    output logic             done,
    output logic             busy,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RUNNING = 2'b01,
        PAUSED  = 2'b10,
        EXPIRED = 2'b11
    } state_t;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_val_q, reload_val_d;
    logic             done_q, done_d;

    // Next-state decode in priority order: stop, start, pause handling, then decrement.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        reload_val_d = reload_val_q;
        done_d       = 1'b0;

        if (stop) begin
            state_d = IDLE;
            count_d = '0;
        end else if (start) begin
            // A start always re-captures the reload value, even as a restart mid-run.
            reload_val_d = load_value;
            if (load_value != '0) begin
                count_d = load_value;
                state_d = RUNNING;
            end else begin
                // Zero load expires at once; auto_reload deliberately not consulted.
                count_d = '0;
                state_d = EXPIRED;
                done_d  = 1'b1;
            end
        end else begin
            unique case (state_q)
                RUNNING: begin
                    if (pause) begin
                        state_d = PAUSED;
                    end else if (count_q == '0) begin
                        // Should not happen; never wrap, just park in EXPIRED.
                        state_d = EXPIRED;
                    end else if (count_q == ONE) begin
                        done_d = 1'b1;
                        if (auto_reload) begin
                            // Skip the zero so the period is exactly reload_val edges.
                            count_d = reload_val_q;
                        end else begin
                            count_d = '0;
                            state_d = EXPIRED;
                        end
                    end else begin
                        count_d = count_q - ONE;
                    end
                end
                PAUSED: begin
                    // Resume edge only changes state; counting restarts on the next edge.
                    if (!pause) begin
                        state_d = RUNNING;
                    end
                end
                default: begin
                    // IDLE and EXPIRED hold until start or stop.
                end
            endcase
        end
    end

    // State and output registers, forced to rest immediately by clear.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q      <= IDLE;
            count_q      <= '0;
            reload_val_q <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            reload_val_q <= reload_val_d;
            done_q       <= done_d;
        end
    end

    assign Q     = count_q;
    assign done  = done_q;
    assign state = state_q;
    assign busy  = (state_q == RUNNING) || (state_q == PAUSED);

endmodule

// File: doc/down_timer.md
DOWN_TIMER -- requirements
Module: down_timer

Interface
REQ-001 Parameter WIDTH, default 16: bit width of the count and load value (legal values: 2 to 32).
REQ-002 clock  input  1: single clock; all state updates on the rising edge.
REQ-003 clear  input  1: asynchronous, active-high reset.
REQ-004 start  input  1: sampled per edge; loads load_value and begins the countdown.
REQ-005 stop  input  1: sampled per edge; aborts and returns to IDLE.
REQ-006 pause  input  1: level; holds the count while high.
REQ-007 auto_reload  input  1: level; sampled at terminal count; selects periodic operation.
REQ-008 load_value  input  WIDTH: initial count; sampled when start is accepted.
REQ-009 Q  output  WIDTH: current count, registered.
REQ-010 done  output  1: registered one-cycle pulse on each terminal count.
REQ-011 busy  output  1: high in RUNNING or PAUSED; decoded from state only.
REQ-012 state  output  2: IDLE=00, RUNNING=01, PAUSED=10, EXPIRED=11.

Function
REQ-013 Internal register reload_val (WIDTH bits) SHALL capture load_value on every accepted start.
REQ-014 Per-edge priority SHALL be clear > stop > start > pause handling > decrement.
REQ-015 stop in any state: state=IDLE, Q=0, done=0.
REQ-016 start with load_value != 0, in any state including RUNNING/PAUSED (restart):
- Q=load_value.
- state=RUNNING.
- done=0.
REQ-017 start with load_value == 0:
- Q=0, state=EXPIRED, done=1 for one cycle.
- auto_reload is ignored.
REQ-018 RUNNING, pause=1: Q holds, state=PAUSED, no decrement on that edge.
REQ-019 PAUSED, pause=1: Q holds.
REQ-020 PAUSED, pause=0: state=RUNNING, Q holds on that edge; decrement resumes on the next edge.
REQ-021 RUNNING, pause=0, Q>1: Q=Q-1.
REQ-022 RUNNING, pause=0, Q==1, auto_reload=0: Q=0, state=EXPIRED, done=1.
REQ-023 RUNNING, pause=0, Q==1, auto_reload=1: Q=reload_val, state stays RUNNING, done=1.
REQ-024 Reload period SHALL be exactly reload_val cycles between done pulses; Q never shows 0 in auto-reload mode.
REQ-025 Latency: start accepted at edge k with N>0 and no pause SHALL give Q=N after edge k and Q=0 with done=1 after edge k+N.
REQ-026 done SHALL be high for exactly one cycle per terminal event and low on every other edge.
REQ-027 Q SHALL never wrap below 0; RUNNING with Q==0 is unreachable, but if it occurs it SHALL go to EXPIRED without decrementing.
REQ-028 IDLE and EXPIRED SHALL hold Q and ignore pause and auto_reload until start or stop.
REQ-029 load_value changes after start SHALL NOT affect the current run or the reload value.

Reset
REQ-030 clear=1 SHALL force immediately, regardless of clock: Q=0, reload_val=0, done=0, state=IDLE, busy=0.
REQ-031 clear asserted mid-count or mid-pause SHALL discard the run; the first edge after clear deasserts SHALL obey REQ-014..REQ-029.
REQ-032 No input other than clear SHALL affect outputs while clear is high.

Verification
REQ-033 The bench SHALL cover the following directed scenarios:
- WIDTH=16, start with load_value=5, pause=0, auto_reload=0 -> Q 5,4,3,2,1,0 on successive edges; done=1 only with Q=0; state=EXPIRED; busy=0.
- load_value=3, auto_reload=1, run 10 cycles -> Q 3,2,1,3,2,1,...; done pulses every 3 cycles; state stays RUNNING.
- load_value=6; pause high for 4 edges when Q=4 -> Q holds 4 through PAUSED plus the resume edge, then 3,2,1,0; done after a total of 6+4+1 edges.
- load_value=0 start -> next edge Q=0, done=1 for one cycle, state=EXPIRED; repeat with auto_reload=1 -> same result.
- Restart with 9 while Q=2 -> Q=9; no done pulse. stop asserted together with start -> IDLE, Q=0.
- clear pulsed asynchronously between edges while Q=7 -> Q=0, state=IDLE immediately; the next start with load_value=2 counts normally.
